// File: rtl/alu_sequencer.sv
// Operand/write-back stage around the SAP-1 adder/subtractor.
// Holds A and B, sequences ADD/SUB over IDLE -> EXEC -> DONE.
module alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cb,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_cout,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_z,
    output logic             op_done,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    localparam logic [2:0] OP_LDA  = 3'd1;
    localparam logic [2:0] OP_LDB  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_OUT  = 3'd5;
    localparam logic [2:0] OP_CLRF = 3'd6;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] breg_q, breg_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_z_q, flag_z_d;
    logic             sub_q, sub_d;
    logic             accept;

    assign accept = cmd_valid && (state_q == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            breg_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            sub_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            breg_q      <= breg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            flag_c_q    <= flag_c_d;
            flag_z_q    <= flag_z_d;
            sub_q       <= sub_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        breg_d      = breg_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        flag_c_d    = flag_c_q;
        flag_z_d    = flag_z_q;
        sub_d       = sub_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_LDA: acc_d = cmd_data;
                        OP_LDB: breg_d = cmd_data;
                        OP_ADD: begin
                            sub_d   = 1'b0;
                            state_d = EXEC;
                        end
                        OP_SUB: begin
                            sub_d   = 1'b1;
                            state_d = EXEC;
                        end
                        OP_OUT: begin
                            out_data_d  = acc_q;
                            out_valid_d = 1'b1;
                        end
                        OP_CLRF: begin
                            flag_c_d = 1'b0;
                            flag_z_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            EXEC: begin
                acc_d    = alu_s;
                flag_c_d = alu_cout;
                flag_z_d = (alu_s == '0);
                state_d  = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and adder control decode from state alone.
    assign cmd_ready = (state_q == IDLE);
    assign alu_cb    = (state_q == EXEC) && sub_q;
    assign op_done   = (state_q == DONE);

    assign alu_a     = acc_q;
    assign alu_b     = breg_q;
    assign acc       = acc_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed plan cases plus random commands
// checked against an arithmetic model of the accumulator machine.
module tb_alu_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = 3'd0;
    logic [W-1:0] cmd_data = '0;
    logic [W-1:0] alu_a, alu_b, alu_s, acc, out_data;
    logic         alu_cb, alu_cout, flag_c, flag_z, op_done, out_valid;

    alu_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cb(alu_cb),
        .alu_s(alu_s), .alu_cout(alu_cout),
        .acc(acc), .flag_c(flag_c), .flag_z(flag_z),
        .op_done(op_done), .out_valid(out_valid), .out_data(out_data)
    );

    // Neighbouring adder/subtractor
    assign {alu_cout, alu_s} = {1'b0, alu_a}
                             + {1'b0, alu_b ^ {W{alu_cb}}}
                             + {{W{1'b0}}, alu_cb};

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] m_acc = '0, m_b = '0, m_out = '0;
    logic         m_c = 1'b0, m_z = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".acc"}, acc, m_acc);
        check({tag, ".alu_a"}, alu_a, m_acc);
        check({tag, ".alu_b"}, alu_b, m_b);
        check({tag, ".c"}, flag_c, m_c);
        check({tag, ".z"}, flag_z, m_z);
        check({tag, ".out_data"}, out_data, m_out);
    endtask

    task automatic send(input logic [2:0] op, input logic [W-1:0] d);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        n = 0;
        while (!cmd_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic model_alu(input logic sub);
        logic [W:0] r;
        if (sub) begin
            m_c   = (m_acc >= m_b);
            m_acc = m_acc - m_b;
        end else begin
            r     = {1'b0, m_acc} + {1'b0, m_b};
            m_c   = r[W];
            m_acc = r[W-1:0];
        end
        m_z = (m_acc == 0);
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] d);
        logic sub;
        if (op == 3'd3 || op == 3'd4) begin
            sub = (op == 3'd4);
            send(op, d);
            check("exec.cb", alu_cb, sub);
            check("exec.ready", cmd_ready, 0);
            check("exec.done", op_done, 0);
            @(posedge clk); #1;
            model_alu(sub);
            check_regs("wb");
            check("wb.done", op_done, 1);
            check("wb.ready", cmd_ready, 0);
            check("wb.cb", alu_cb, 0);
            check("wb.out_valid", out_valid, 0);
            @(posedge clk); #1;
            check("idle.done", op_done, 0);
            check("idle.ready", cmd_ready, 1);
        end else begin
            send(op, d);
            case (op)
                3'd1: m_acc = d;
                3'd2: m_b = d;
                3'd5: m_out = m_acc;
                3'd6: begin m_c = 1'b0; m_z = 1'b0; end
                default: ;
            endcase
            check_regs("simple");
            check("simple.out_valid", out_valid, op == 3'd5);
            check("simple.done", op_done, 0);
            check("simple.ready", cmd_ready, 1);
        end
    endtask

    initial begin
        #2;
        check_regs("por");
        check("por.done", op_done, 0);
        check("por.out_valid", out_valid, 0);
        @(negedge clk); rst = 1'b0;
        #1 check("por.ready", cmd_ready, 1);

        // Load/add
        run_cmd(3'd1, 8'h12);
        run_cmd(3'd2, 8'h34);
        run_cmd(3'd3, 8'h00);
        check("add.acc46", acc, 8'h46);
        run_cmd(3'd5, 8'h00);
        check("out.46", out_data, 8'h46);
        run_cmd(3'd7, 8'h5A);

        // Wrap-around then clear flags
        run_cmd(3'd1, 8'hFF);
        run_cmd(3'd2, 8'h01);
        run_cmd(3'd3, 8'h00);
        check("wrap.cz", {flag_c, flag_z}, 2'b11);
        run_cmd(3'd6, 8'h00);

        // Subtract with and without borrow
        run_cmd(3'd1, 8'h05);
        run_cmd(3'd2, 8'h07);
        run_cmd(3'd4, 8'h00);
        check("sub.fe", acc, 8'hFE);
        run_cmd(3'd1, 8'h07);
        run_cmd(3'd4, 8'h00);
        check("sub.zero", {flag_c, flag_z, acc}, 10'h300);

        // LDA held during EXEC/DONE waits for IDLE
        run_cmd(3'd1, 8'h12);
        run_cmd(3'd2, 8'h34);
        send(3'd3, 8'h00);
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 8'hAA;
        model_alu(1'b0);
        @(posedge clk); #1;
        check("hold.exec_acc", acc, m_acc);
        @(posedge clk); #1;
        check("hold.done_acc", acc, m_acc);
        check("hold.ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        m_acc = 8'hAA;
        check_regs("hold.accepted");

        // Back-to-back simple commands
        run_cmd(3'd1, 8'h3C);
        run_cmd(3'd2, 8'hC3);
        run_cmd(3'd5, 8'h00);
        run_cmd(3'd0, 8'h00);

        for (int i = 0; i < 150; i++)
            run_cmd(3'($urandom_range(0, 7)), W'($urandom));

        // Reset in the middle of an ADD
        run_cmd(3'd1, 8'h21);
        run_cmd(3'd5, 8'h00);
        send(3'd3, 8'h00);
        rst = 1'b1;
        #1;
        m_acc = '0; m_b = '0; m_out = '0; m_c = 1'b0; m_z = 1'b0;
        check_regs("rst");
        check("rst.cb", alu_cb, 0);
        check("rst.done", op_done, 0);
        check("rst.out_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1 check("rst.hold_done", op_done, 0);
        @(negedge clk); rst = 1'b0;
        #1;
        check("rst.ready", cmd_ready, 1);
        check("rst.acc", acc, 0);
        @(posedge clk); #1;
        check("rst.no_done", op_done, 0);
        run_cmd(3'd1, 8'h09);
        run_cmd(3'd2, 8'h0A);
        run_cmd(3'd3, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven operand and write-back stage for the SAP-1 adder/subtractor. It holds the accumulator (A) and B registers and drives them onto the adder/subtractor's `a`/`b`/`cb` inputs. It captures the sum and carry-out back into the accumulator and flag registers. It sits directly upstream and downstream of the adder/subtractor, between the controller's command interface and the output register.

## Interface
- `WIDTH`, default 8: datapath width of A, B, sum and output.
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `cmd_valid`: input, 1 bit. Command present.
- `cmd_ready`: output, 1 bit. Block can accept a command.
- `cmd_op`: input, 3 bits. 0 NOP, 1 LDA, 2 LDB, 3 ADD, 4 SUB, 5 OUT, 6 CLRF, 7 treated as NOP.
- `cmd_data`: input, WIDTH bits. Load value for LDA/LDB; ignored otherwise.
- `alu_a`: output, WIDTH bits. To adder/subtractor `a`; always equals `acc`.
- `alu_b`: output, WIDTH bits. To adder/subtractor `b`; always equals B register.
- `alu_cb`: output, 1 bit. To adder/subtractor `cb`; 1 only in EXEC of a SUB, else 0.
- `alu_s`: input, WIDTH bits. Adder/subtractor sum.
- `alu_cout`: input, 1 bit. Adder/subtractor carry-out.
- `acc`: output, WIDTH bits. Accumulator contents.
- `flag_c`: output, 1 bit. Carry flag (for SUB: 1 = no borrow).
- `flag_z`: output, 1 bit. Zero flag.
- `op_done`: output, 1 bit. One-cycle pulse when ADD/SUB write-back is visible.
- `out_valid`: output, 1 bit. One-cycle pulse with `out_data`.
- `out_data`: output, WIDTH bits. Registered copy of `acc` taken by OUT.

## Operation
- States: IDLE, EXEC, DONE.
- A command is accepted on a rising edge where `cmd_valid && cmd_ready`.
- `cmd_ready` is 1 only in IDLE.
- LDA: `acc <= cmd_data` at the accept edge. Stay in IDLE. Flags unchanged.
- LDB: `breg <= cmd_data` at the accept edge. Stay in IDLE.
- OUT: at the accept edge, `out_data <= acc` (value before the edge) and `out_valid <= 1` for exactly one cycle. Stay in IDLE.
- CLRF: `flag_c <= 0` and `flag_z <= 0`. Stay in IDLE.
- NOP and op 7: no register change. Stay in IDLE.
- ADD/SUB, accept edge: latch the sub bit and go to EXEC.
- ADD/SUB, EXEC: `alu_cb` = sub bit while `alu_a`/`alu_b` are held stable.
- ADD/SUB, edge leaving EXEC:
  - `acc <= alu_s`
  - `flag_c <= alu_cout`
  - `flag_z <= (alu_s == 0)`
  - go to DONE.
- DONE: `op_done` = 1 for this one cycle. Unconditionally return to IDLE on the next edge.
- Commands presented while not in IDLE are not accepted. The upstream must hold `cmd_valid` and `cmd_op`/`cmd_data` stable until accepted.
- `alu_s` and `alu_cout` are sampled only on the edge leaving EXEC. They are don't-care in every other cycle.
- Arithmetic is modulo 2^WIDTH. The expected adder behaviour is `s = a + (b ^ {WIDTH{cb}}) + cb` with `cout` as the carry out of the MSB.
- The B register is never modified by ADD/SUB.

## Timing
- Reset (async, immediate): state IDLE; `acc`, `breg`, `out_data` = 0; `flag_c`, `flag_z`, `alu_cb`, `op_done`, `out_valid` = 0; `cmd_ready` = 1 once `rst` deasserts.
- Reset during EXEC or DONE aborts the operation. Reset values apply and no `op_done` is produced.
- LDA/LDB/OUT/CLRF/NOP:
  - effect is visible the cycle after the accept edge;
  - `cmd_ready` stays high, so back-to-back commands are accepted every cycle.
- ADD/SUB, with the accept edge at T0:
  - EXEC during T0→T1;
  - `acc`/flags updated at T1;
  - `op_done` high during T1→T2;
  - `cmd_ready` high again after T2.
  - Throughput is one ALU op per 3 cycles.
- OUT accepted immediately after ADD/SUB outputs the post-write-back `acc`.
- `out_valid` and `op_done` never assert in the same cycle.
- Outputs `alu_a`, `alu_b`, `acc`, `flag_*` and `out_data` are register-driven. `alu_cb` and `cmd_ready` are decoded from state only, with no input-to-output combinational path.

## Test plan
- Reset: assert `rst` mid-ADD (during EXEC) → all outputs 0 immediately, no `op_done`. After release, `cmd_ready` = 1 and `acc` = 0x00.
- Load/add: LDA 0x12, LDB 0x34, ADD → `alu_cb` = 0 in EXEC. At the write-back edge `acc` = 0x46, C = 0, Z = 0. `op_done` pulses once. `cmd_ready` is low for exactly 2 cycles.
- Wrap-around: LDA 0xFF, LDB 0x01, ADD → `acc` = 0x00, C = 1, Z = 1. Then CLRF → C = 0, Z = 0 and `acc` stays 0x00.
- Subtract: LDA 0x05, LDB 0x07, SUB → `alu_cb` = 1 in EXEC only, `acc` = 0xFE, C = 0, Z = 0. Then LDA 0x07, SUB → `acc` = 0x00, C = 1, Z = 1.
- Handshake: hold `cmd_valid` with LDA 0xAA during EXEC/DONE of an ADD → not accepted until IDLE, then accepted at the first IDLE edge. Back-to-back LDA, LDB, OUT in consecutive cycles are all accepted.
- Output: ADD yielding 0x46, then OUT → `out_valid` is a single-cycle pulse with `out_data` = 0x46. An op-7 command changes nothing.
